wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_arb_pkg.sv | 28 ++
 rtl/wb_port_arbiter_if.sv | 29 ++
 rtl/wb_fifo2.sv | 60 ++++++
 rtl/wb_port_arbiter.sv | 117 +++++++++++
 tb/tb_wb_port_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and sizing for the register-file writeback port arbiter.
// Two requesters (ALU and load writeback) feed one register-file write port.
package wb_arb_pkg;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 3;
   localparam int NUM_REGS   = 8;
   localparam int FIFO_DEPTH = 2;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_entry_t;

   function automatic logic [NUM_REGS-1:0] addr_decode(input logic [ADDR_W-1:0] a);
      logic [NUM_REGS-1:0] d;
      d    = '0;
      d[a] = 1'b1;
      return d;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the two writeback requesters, the arbiter and the register file.
// The arbiter sits on the slave modport; the requesters/register file side uses master.
interface wb_port_arbiter_if;
   import wb_arb_pkg::*;

   logic                A_valid;
   logic [ADDR_W-1:0]   A_addr;
   logic [DATA_W-1:0]   A_data;
   logic                A_ready;
   logic                B_valid;
   logic [ADDR_W-1:0]   B_addr;
   logic [DATA_W-1:0]   B_data;
   logic                B_ready;
   logic                Reg_Write;
   logic [ADDR_W-1:0]   Reg_address3;
   logic [DATA_W-1:0]   Reg_input_data;
   logic [NUM_REGS-1:0] Pending;

   modport slave (
      input  A_valid, A_addr, A_data, B_valid, B_addr, B_data,
      output A_ready, B_ready, Reg_Write, Reg_address3, Reg_input_data, Pending
   );

   modport master (
      output A_valid, A_addr, A_data, B_valid, B_addr, B_data,
      input  A_ready, B_ready, Reg_Write, Reg_address3, Reg_input_data, Pending
   );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry in-order FIFO for one writeback requester; slot 0 is always the head.
// Exposes count, head and per-entry addresses so the arbiter can build Pending.
module wb_fifo2
   import wb_arb_pkg::*;
(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               push,
   input  wr_entry_t                          push_entry,
   input  logic                               pop,
   output logic [CNT_W-1:0]                   count,
   output wr_entry_t                          head,
   output logic [FIFO_DEPTH-1:0]              entry_valid,
   output logic [FIFO_DEPTH-1:0][ADDR_W-1:0]  entry_addr
);

   logic [CNT_W-1:0]            cnt;
   wr_entry_t [FIFO_DEPTH-1:0]  slot;
   logic                        push_ok;
   logic                        pop_ok;

   // A full FIFO refuses pushes even when it pops in the same cycle.
   assign push_ok = push && (cnt < CNT_W'(FIFO_DEPTH));
   assign pop_ok  = pop && (cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         slot <= '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               slot[cnt[0]] <= push_entry;
               cnt          <= cnt + CNT_W'(1);
            end
            2'b01: begin
               slot[0] <= slot[1];
               cnt     <= cnt - CNT_W'(1);
            end
            2'b11: begin
               // Only reachable with one entry: the new write becomes the head.
               slot[0] <= push_entry;
            end
            default: ;
         endcase
      end
   end

   assign count       = cnt;
   assign head        = slot[0];
   assign entry_valid = {cnt == CNT_W'(2), cnt != '0};

   always_comb begin
      entry_addr = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         entry_addr[i] = slot[i].addr;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto one registered register-file write port.
// Default is round-robin with A winning same-address ties; define WB_ARB_FIXED_PRIO_EN for fixed A priority.
module wb_port_arbiter
   import wb_arb_pkg::*;
(
   input  logic              CLK,
   input  logic              Reset_n,
   wb_port_arbiter_if.slave  bus
);

   logic [CNT_W-1:0]                   cnt_a, cnt_b;
   wr_entry_t                          head_a, head_b;
   logic [FIFO_DEPTH-1:0]              ev_a, ev_b;
   logic [FIFO_DEPTH-1:0][ADDR_W-1:0]  ea_a, ea_b;
   logic                               ready_a, ready_b;
   logic                               grant_a, grant_b;
   logic                               reg_write_q;
   logic [ADDR_W-1:0]                  reg_addr_q;
   logic [DATA_W-1:0]                  reg_data_q;
   logic [NUM_REGS-1:0]                pending;

   assign ready_a = cnt_a < CNT_W'(FIFO_DEPTH);
   assign ready_b = cnt_b < CNT_W'(FIFO_DEPTH);

   wb_fifo2 u_fifo_a (
      .clk         (CLK),
      .rst_n       (Reset_n),
      .push        (bus.A_valid && ready_a),
      .push_entry  ({bus.A_addr, bus.A_data}),
      .pop         (grant_a),
      .count       (cnt_a),
      .head        (head_a),
      .entry_valid (ev_a),
      .entry_addr  (ea_a)
   );

   wb_fifo2 u_fifo_b (
      .clk         (CLK),
      .rst_n       (Reset_n),
      .push        (bus.B_valid && ready_b),
      .push_entry  ({bus.B_addr, bus.B_data}),
      .pop         (grant_b),
      .count       (cnt_b),
      .head        (head_b),
      .entry_valid (ev_b),
      .entry_addr  (ea_b)
   );

`ifdef WB_ARB_FIXED_PRIO_EN
   always_comb begin
      grant_a = ev_a[0];
      grant_b = ev_b[0] && !ev_a[0];
   end
`else
   req_id_t last_grant;

   // Same-address heads go to A first so the load result lands last.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (ev_a[0] && ev_b[0]) begin
         if ((head_a.addr == head_b.addr) || (last_grant == REQ_B)) begin
            grant_a = 1'b1;
         end else begin
            grant_b = 1'b1;
         end
      end else begin
         grant_a = ev_a[0];
         grant_b = ev_b[0];
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         last_grant <= REQ_B;
      end else if (grant_a) begin
         last_grant <= REQ_A;
      end else if (grant_b) begin
         last_grant <= REQ_B;
      end
   end
`endif

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         reg_write_q <= 1'b0;
         reg_addr_q  <= '0;
         reg_data_q  <= '0;
      end else begin
         reg_write_q <= grant_a || grant_b;
         if (grant_a) begin
            reg_addr_q <= head_a.addr;
            reg_data_q <= head_a.data;
         end else if (grant_b) begin
            reg_addr_q <= head_b.addr;
            reg_data_q <= head_b.data;
         end
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (ev_a[i]) pending = pending | addr_decode(ea_a[i]);
         if (ev_b[i]) pending = pending | addr_decode(ea_b[i]);
      end
      if (reg_write_q) pending = pending | addr_decode(reg_addr_q);
   end

   assign bus.A_ready        = ready_a;
   assign bus.B_ready        = ready_b;
   assign bus.Reg_Write      = reg_write_q;
   assign bus.Reg_address3   = reg_addr_q;
   assign bus.Reg_input_data = reg_data_q;
   assign bus.Pending        = pending;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-level reference model predicts each
// register-file write; a negedge monitor compares outputs, ready and Pending every cycle.
module tb_wb_port_arbiter;

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] data;
   } item_t;

   logic CLK;
   logic Reset_n;

   wb_port_arbiter_if bus ();

   wb_port_arbiter dut (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   item_t src_a[$], src_b[$];
   item_t qa[$], qb[$];
   item_t exp_q[$];
   bit         last_b     = 1'b1;
   bit         m_out_v    = 1'b0;
   logic [2:0] m_out_addr = '0;
   bit         rand_mode  = 1'b0;
   logic [15:0] regfile [8];

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_pending();
      logic [7:0] p;
      p = '0;
      foreach (qa[i]) p[qa[i].addr] = 1'b1;
      foreach (qb[i]) p[qb[i].addr] = 1'b1;
      if (m_out_v) p[m_out_addr] = 1'b1;
      return p;
   endfunction

   // Reference model: two bounded queues, one grant per cycle by the arbitration rules.
   always @(posedge CLK or negedge Reset_n) begin
      bit acc_a, acc_b;
      int g;
      if (!Reset_n) begin
         qa.delete(); qb.delete(); exp_q.delete();
         src_a.delete(); src_b.delete();
         last_b = 1'b1;
         m_out_v = 1'b0;
         m_out_addr = '0;
      end else begin
         acc_a = (bus.A_valid === 1'b1) && (qa.size() < 2);
         acc_b = (bus.B_valid === 1'b1) && (qb.size() < 2);
         g = 0;
         if (qa.size() != 0 && qb.size() != 0) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            g = 1;
`else
            g = (qa[0].addr == qb[0].addr || last_b) ? 1 : 2;
`endif
         end else if (qa.size() != 0) g = 1;
         else if (qb.size() != 0) g = 2;
         m_out_v = (g != 0);
         if (g == 1) begin
            exp_q.push_back(qa[0]); m_out_addr = qa[0].addr;
            void'(qa.pop_front()); last_b = 1'b0;
         end else if (g == 2) begin
            exp_q.push_back(qb[0]); m_out_addr = qb[0].addr;
            void'(qb.pop_front()); last_b = 1'b1;
         end
         if (acc_a) begin
            qa.push_back('{bus.A_addr, bus.A_data});
            if (src_a.size() != 0) void'(src_a.pop_front());
         end
         if (acc_b) begin
            qb.push_back('{bus.B_addr, bus.B_data});
            if (src_b.size() != 0) void'(src_b.pop_front());
         end
      end
   end

   // Driver: present the front of each source queue, holding it until accepted.
   always @(negedge CLK) begin
      if (Reset_n && src_a.size() != 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
         bus.A_valid = 1'b1; bus.A_addr = src_a[0].addr; bus.A_data = src_a[0].data;
      end else begin
         bus.A_valid = 1'b0;
      end
      if (Reset_n && src_b.size() != 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
         bus.B_valid = 1'b1; bus.B_addr = src_b[0].addr; bus.B_data = src_b[0].data;
      end else begin
         bus.B_valid = 1'b0;
      end
   end

   // Monitor / scoreboard.
   always @(negedge CLK) begin
      item_t e;
      if (Reset_n) begin
         check("A_ready", {31'd0, bus.A_ready}, {31'd0, qa.size() < 2});
         check("B_ready", {31'd0, bus.B_ready}, {31'd0, qb.size() < 2});
         check("Pending", {24'd0, bus.Pending}, {24'd0, model_pending()});
         check("Reg_Write", {31'd0, bus.Reg_Write}, {31'd0, exp_q.size() != 0});
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (bus.Reg_Write === 1'b1) begin
               check("Reg_address3", {29'd0, bus.Reg_address3}, {29'd0, e.addr});
               check("Reg_input_data", {16'd0, bus.Reg_input_data}, {16'd0, e.data});
               regfile[bus.Reg_address3] = bus.Reg_input_data;
            end
         end
      end
   end

   task automatic wait_idle(input int max_cyc);
      int n;
      bit idle;
      n = 0;
      idle = 1'b0;
      while (!idle && n < max_cyc) begin
         @(negedge CLK);
         n++;
         idle = (src_a.size() == 0 && src_b.size() == 0 && qa.size() == 0 &&
                 qb.size() == 0 && exp_q.size() == 0);
      end
      check("drain_done", {31'd0, idle}, 32'd1);
      @(negedge CLK);
   endtask

   task automatic check_outputs_clear(input string tag);
      check({tag, "_Reg_Write"}, {31'd0, bus.Reg_Write}, 32'd0);
      check({tag, "_Reg_address3"}, {29'd0, bus.Reg_address3}, 32'd0);
      check({tag, "_Reg_input_data"}, {16'd0, bus.Reg_input_data}, 32'd0);
      check({tag, "_Pending"}, {24'd0, bus.Pending}, 32'd0);
      check({tag, "_A_ready"}, {31'd0, bus.A_ready}, 32'd1);
      check({tag, "_B_ready"}, {31'd0, bus.B_ready}, 32'd1);
   endtask

   initial begin
      foreach (regfile[i]) regfile[i] = '0;
      bus.A_valid = 1'b0; bus.A_addr = '0; bus.A_data = '0;
      bus.B_valid = 1'b0; bus.B_addr = '0; bus.B_data = '0;
      Reset_n = 1'b0;
      #12;
      check_outputs_clear("reset");
      @(posedge CLK); #2 Reset_n = 1'b1;

      // Single A write: addr 3, data 1234.
      src_a.push_back('{3'd3, 16'h1234});
      wait_idle(20);
      check("single_regfile3", {16'd0, regfile[3]}, 32'h1234);

      // Both requesters saturated, six writes each, heads never share an address.
      for (int i = 0; i < 6; i++) begin
         src_a.push_back('{3'(i), 16'hA000 + 16'(i)});
         src_b.push_back('{3'((i + 3) % 8), 16'hB000 + 16'(i)});
      end
      wait_idle(60);

      // Same destination on both heads: A first, B's data remains.
      src_a.push_back('{3'd5, 16'h00AA});
      src_b.push_back('{3'd5, 16'h00BB});
      wait_idle(20);
      check("same_addr_final", {16'd0, regfile[5]}, 32'h00BB);

      // Reset in the middle of a saturated stream.
      for (int i = 0; i < 8; i++) begin
         src_a.push_back('{3'($urandom_range(0, 7)), 16'($urandom)});
         src_b.push_back('{3'($urandom_range(0, 7)), 16'($urandom)});
      end
      repeat (4) @(posedge CLK);
      #2 Reset_n = 1'b0;
      #1 check_outputs_clear("midreset");
      @(posedge CLK); #2 Reset_n = 1'b1;
      repeat (10) @(negedge CLK);

      // Randomised traffic with random valid gaps.
      rand_mode = 1'b1;
      for (int i = 0; i < 200; i++) begin
         src_a.push_back('{3'($urandom_range(0, 7)), 16'($urandom)});
         src_b.push_back('{3'($urandom_range(0, 7)), 16'($urandom)});
      end
      wait_idle(3000);
      rand_mode = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
